// File: rtl/mips_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_sequencer
// Purpose  : Sequences instruction fetch and optional load/store for a
//            single-cycle MIPS core over one shared variable-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mem_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] data,
    output logic              hold,
    output logic [31:0]       retired,
    output logic              mreq,
    output logic              mwe,
    output logic [ADDR_W-1:0] maddr,
    output logic [DATA_W-1:0] mwdata,
    input  logic [DATA_W-1:0] mrdata,
    input  logic              mack
);

    localparam logic [1:0] c_FETCH  = 2'd0;
    localparam logic [1:0] c_EXEC   = 2'd1;
    localparam logic [1:0] c_DATA   = 2'd2;
    localparam logic [1:0] c_COMMIT = 2'd3;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_instruction;
    logic [DATA_W-1:0] r_data;
    logic [31:0]       r_retired;

    logic w_in_fetch;
    logic w_in_data;
    logic w_done;
    logic w_load_only;

    assign w_in_fetch  = (r_state == c_FETCH);
    assign w_in_data   = (r_state == c_DATA);
    // mreq is already gated by reset, so a late mack cannot complete anything
    assign w_done      = mreq & mack;
    // A simultaneous read and write is treated as a write; data is not loaded
    assign w_load_only = mem_read & ~mem_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_FETCH;
            r_instruction <= '0;
            r_data        <= '0;
            r_retired     <= '0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (w_done) begin
                        r_instruction <= mrdata;
                        r_state       <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    if (mem_read || mem_write) begin
                        r_state <= c_DATA;
                    end else begin
                        r_state <= c_COMMIT;
                    end
                end
                c_DATA: begin
                    if (w_done) begin
                        if (w_load_only) begin
                            r_data <= mrdata;
                        end
                        r_state <= c_COMMIT;
                    end
                end
                default: begin
                    r_retired <= r_retired + 32'd1;
                    r_state   <= c_FETCH;
                end
            endcase
        end
    end

    assign mreq        = ~reset & (w_in_fetch | w_in_data);
    assign mwe         = ~reset & w_in_data & mem_write;
    assign maddr       = w_in_data ? data_address : pc;
    assign mwdata      = write_data;
    assign hold        = reset | (r_state != c_COMMIT);
    assign instruction = r_instruction;
    assign data        = r_data;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mem_sequencer
// Purpose  : Self-checking bench; plays core and memory around the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, data_address, write_data, mrdata;
    logic        mem_read, mem_write, mack;
    logic [31:0] instruction, data, retired, maddr, mwdata;
    logic        hold, mreq, mwe;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hold_lows = 0;

    // Reference state: what the core/memory should see at the architectural level
    logic [31:0] m_pc, m_retired, m_data, m_instr;

    mips_mem_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .pc(pc), .data_address(data_address),
        .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
        .instruction(instruction), .data(data), .hold(hold), .retired(retired),
        .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
        .mrdata(mrdata), .mack(mack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) hold_lows <= 0;
        else if (hold === 1'b0) hold_lows <= hold_lows + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction: wf fetch cycles, EXEC, wd data cycles if accessing, COMMIT.
    // abort_after > 0 asserts reset after that many unanswered data cycles.
    task automatic run_instr(input int wf, input int wd, input bit rd, input bit wr,
                             input logic [31:0] addr, input logic [31:0] wdat,
                             input logic [31:0] iword, input logic [31:0] rword,
                             input int abort_after);
        int  start;
        bit  acc;
        acc   = rd | wr;
        start = 0;
        for (int c = 1; c <= wf; c++) begin
            @(negedge clk);
            reset        = 1'b0;
            pc           = m_pc;
            mem_read     = 1'($urandom);
            mem_write    = 1'($urandom);
            data_address = $urandom;
            mack         = (c == wf);
            mrdata       = (c == wf) ? iword : $urandom;
            #1;
            if (c == 1) begin
                start = cyc;
                chk("fetch_retired", retired, m_retired);
            end
            chk("fetch_mreq", {31'd0, mreq}, 32'd1);
            chk("fetch_mwe", {31'd0, mwe}, 32'd0);
            chk("fetch_maddr", maddr, m_pc);
            chk("fetch_hold", {31'd0, hold}, 32'd1);
        end
        m_instr = iword;

        @(negedge clk);
        mem_read     = rd;
        mem_write    = wr;
        data_address = addr;
        write_data   = wdat;
        mack         = 1'($urandom);
        mrdata       = $urandom;
        #1;
        chk("exec_mreq", {31'd0, mreq}, 32'd0);
        chk("exec_hold", {31'd0, hold}, 32'd1);
        chk("exec_instr", instruction, m_instr);
        chk("exec_data", data, m_data);

        if (acc) begin
            for (int c = 1; c <= wd; c++) begin
                @(negedge clk);
                if (abort_after > 0 && c == abort_after + 1) begin
                    reset  = 1'b1;
                    mack   = 1'b1;
                    mrdata = $urandom;
                    #1;
                    chk("rst_mreq", {31'd0, mreq}, 32'd0);
                    chk("rst_hold", {31'd0, hold}, 32'd1);
                    m_pc = 0; m_retired = 0; m_data = 0; m_instr = 0;
                    @(negedge clk);
                    mack = 1'b0;
                    #1;
                    chk("rst_instr", instruction, 32'd0);
                    chk("rst_data", data, 32'd0);
                    chk("rst_retired", retired, 32'd0);
                    return;
                end
                mack   = (c == wd);
                mrdata = (c == wd) ? rword : $urandom;
                #1;
                chk("data_mreq", {31'd0, mreq}, 32'd1);
                chk("data_mwe", {31'd0, mwe}, {31'd0, wr});
                chk("data_maddr", maddr, addr);
                chk("data_mwdata", mwdata, wdat);
                chk("data_hold", {31'd0, hold}, 32'd1);
            end
            if (rd && !wr) m_data = rword;
        end

        @(negedge clk);
        mack   = 1'($urandom);
        mrdata = $urandom;
        #1;
        chk("commit_hold", {31'd0, hold}, 32'd0);
        chk("commit_mreq", {31'd0, mreq}, 32'd0);
        chk("commit_instr", instruction, m_instr);
        chk("commit_data", data, m_data);
        chk("commit_retired", retired, m_retired);
        chk("commit_cycles", cyc - start + 1, wf + 2 + (acc ? wd : 0));
        m_retired = m_retired + 1;
        m_pc      = m_pc + 4;
    endtask

    initial begin
        reset = 1'b1; mack = 1'b1; mrdata = 32'hFFFF_FFFF;
        pc = 0; data_address = 0; write_data = 0; mem_read = 1'b1; mem_write = 1'b1;
        m_pc = 0; m_retired = 0; m_data = 0; m_instr = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_hold", {31'd0, hold}, 32'd1);
        chk("reset_mreq", {31'd0, mreq}, 32'd0);
        chk("reset_mwe", {31'd0, mwe}, 32'd0);
        chk("reset_instr", instruction, 32'd0);
        chk("reset_data", data, 32'd0);
        chk("reset_retired", retired, 32'd0);

        // Zero-wait add at address 0
        run_instr(1, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0108_2020, 32'h0, 0);
        // lw 0x100 with waits: 7 cycles total
        run_instr(2, 3, 1'b1, 1'b0, 32'h100, 32'h0, 32'h8C01_0100, 32'hDEAD_BEEF, 0);
        // sw 0x104
        run_instr(1, 1, 1'b0, 1'b1, 32'h104, 32'h1234_5678, 32'hAC01_0104, 32'h5555_AAAA, 0);
        // read and write together: write wins, data unchanged
        run_instr(2, 2, 1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 32'hFFFF_0000, 32'h7777_7777, 0);
        // Reset during a data wait, then restart from address 0
        run_instr(1, 5, 1'b1, 1'b0, 32'h300, 32'h0, 32'h8C02_0300, 32'h1111_1111, 2);
        run_instr(1, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0020, 32'h0, 0);

        for (int i = 0; i < 50; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            run_instr(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                      kind[0], kind[1], $urandom, $urandom, $urandom, $urandom, 0);
        end

        @(negedge clk);
        #1;
        chk("final_retired_model", retired, m_retired);
        chk("final_retired_holds", retired, hold_lows);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
